// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder reused by the serial datapath
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract over W cycles, LSB first, with held result
module serial_adder #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int CW = $clog2(W + 1);
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic          state;
    logic [W-1:0]  ra, rb, rs;
    logic          c;
    logic [CW-1:0] cnt;
    logic          sb, cb;

    fa_cell u_fa (
        .a  (ra[0]),
        .b  (rb[0]),
        .ci (c),
        .s  (sb),
        .co (cb)
    );

    // capture operands on start, then shift one bit per cycle; publish s/co only on the last bit
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    ra    <= a;
                    rb    <= sub ? ~b : b;
                    c     <= sub | ci;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else begin
                ra  <= ra >> 1;
                rb  <= rb >> 1;
                rs  <= {sb, rs[W-1:1]};
                c   <= cb;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    s     <= {sb, rs[W-1:1]};
                    co    <= cb;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder with W=8
module tb_serial_adder;
    localparam int W = 8;

    logic         ck = 1'b0;
    logic         rst, start, sub, ci;
    logic [W-1:0] a, b;
    logic         busy, done, co;
    logic [W-1:0] s;

    int passed = 0;
    int total  = 0;

    serial_adder #(.W(W)) dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci, input logic vsub);
        a = va; b = vb; ci = vci; sub = vsub; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vci, input logic vsub, input logic [W-1:0] es, input logic eco);
        logic ok_busy;
        launch(va, vb, vci, vsub);
        ok_busy = busy & ~done;
        for (int i = 1; i < W; i++) begin
            @(negedge ck);
            ok_busy = ok_busy & busy & ~done;
        end
        chk({tag, "_busy_run"}, 32'(ok_busy), 32'd1);
        @(negedge ck);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_co"}, 32'(co), 32'(eco));
        @(negedge ck);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_s_hold"}, 32'(s), 32'(es));
    endtask

    initial begin
        int n, ndone, di;
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        @(negedge ck); @(negedge ck);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);

        run_op("add_basic", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        run_op("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_op("sub_80_80", 8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1);
        run_op("sub_ci_ign", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
        run_op("sub_05_03_c", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1);

        launch(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge ck); @(negedge ck);
        a = 8'h7F; b = 8'h7F; start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        ndone = 0; di = 0;
        for (int i = 4; i <= 20; i++) begin
            @(negedge ck);
            if (done) begin ndone++; di = i; end
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_lat", 32'(di), 32'd8);
        chk("busy_start_s", 32'(s), 32'h02);
        chk("busy_start_co", 32'(co), 32'd0);

        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        n = 0;
        while (!done && n < 20) begin @(negedge ck); n++; end
        chk("b2b_first_lat", 32'(n), 32'd8);
        chk("b2b_first_s", 32'(s), 32'h96);
        launch(8'h11, 8'h22, 1'b0, 1'b0);
        n = 1;
        while (!done && n < 20) begin @(negedge ck); n++; end
        chk("b2b_gap", 32'(n), 32'd9);
        chk("b2b_s", 32'(s), 32'h33);
        chk("b2b_co", 32'(co), 32'd0);

        launch(8'hAA, 8'h55, 1'b0, 1'b0);
        @(negedge ck); @(negedge ck); @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        chk("rst_mid_s", 32'(s), 32'd0);
        chk("rst_mid_co", 32'(co), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            if (done) ndone++;
        end
        chk("rst_mid_nodone", 32'(ndone), 32'd0);
        run_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
